// File: rtl/cache_mem_arbiter.sv
// Word-serial burst sequencer sharing one memory port between I-cache refills and
// D-cache refills/write-backs, with round-robin arbitration on simultaneous requests.
module cache_mem_arbiter #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_W     = 32,
    localparam int unsigned IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic [31:0]       ic_rdata,
    output logic              ic_valid,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [31:0]       dc_wdata,
    output logic              dc_gnt,
    output logic [31:0]       dc_rdata,
    output logic              dc_valid,
    output logic              dc_done,
    output logic [IDX_W-1:0]  word_idx,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_dout,
    input  logic [31:0]       mem_din,
    input  logic              mem_ack
);

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              we_q, we_d;
    // Doubles as last_gnt: it keeps pointing at the previous owner between bursts.
    logic              dc_own_q, dc_own_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              valid_q, valid_d;
    logic [IDX_W-1:0]  vidx_q, vidx_d;
    logic              grant_dc;
    logic              busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            base_q   <= '0;
            we_q     <= 1'b0;
            dc_own_q <= 1'b0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            vidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            we_q     <= we_d;
            dc_own_q <= dc_own_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            vidx_q   <= vidx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        we_d     = we_q;
        dc_own_d = dc_own_q;
        rdata_d  = rdata_q;
        valid_d  = 1'b0;
        vidx_d   = vidx_q;
        grant_dc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ic_req || dc_req) begin
                    // On a tie the D-cache wins unless it owned the previous burst.
                    grant_dc = dc_req && (!ic_req || !dc_own_q);
                    dc_own_d = grant_dc;
                    base_d   = (grant_dc ? dc_addr : ic_addr) & ~OFF_MASK;
                    we_d     = grant_dc && dc_we;
                    cnt_d    = '0;
                    state_d  = StBurst;
                end
            end
            StBurst: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (!we_q) begin
                        rdata_d = mem_din;
                        valid_d = 1'b1;
                        vidx_d  = cnt_q;
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q == StBurst) || (state_q == StDone);
        ic_gnt   = busy && !dc_own_q;
        dc_gnt   = busy && dc_own_q;
        ic_valid = valid_q && !dc_own_q;
        dc_valid = valid_q && dc_own_q;
        ic_done  = (state_q == StDone) && !dc_own_q;
        dc_done  = (state_q == StDone) && dc_own_q;
        ic_rdata = dc_own_q ? '0 : rdata_q;
        dc_rdata = dc_own_q ? rdata_q : '0;
        mem_cs   = (state_q == StBurst);
        mem_we   = mem_cs && we_q;
        mem_addr = mem_cs ? (base_q | ADDR_W'({cnt_q, 2'b00})) : '0;
        mem_dout = mem_cs ? dc_wdata : '0;
        // Read beats report the index of the word just returned; write beats the word in flight.
        word_idx = valid_q ? vidx_q : (mem_cs ? cnt_q : '0);
    end

endmodule
